// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: sets the behaviour mode of all four ghosts.
// It runs the global scatter/chase schedule, the shared frightened timer, the
// per-ghost mode FSMs, the eat-combo index and the reversal pulses.
// All timers advance only on the frame tick. Every output is registered.
module ghost_mode_ctrl #(
  parameter int SCATTER_LONG  = 420,
  parameter int SCATTER_SHORT = 300,
  parameter int CHASE_LEN     = 1200,
  parameter int FRIGHT_LEN    = 360,
  parameter int FLASH_LEN     = 120
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_game_start,
  input  logic       i_power_pellet,
  input  logic [3:0] i_ghost_eaten,
  input  logic [3:0] i_ghost_home,
  input  logic [3:0] i_release,
  output logic [3:0] o_blinky_state,
  output logic [3:0] o_pinky_state,
  output logic [3:0] o_inky_state,
  output logic [3:0] o_clyde_state,
  output logic [3:0] o_sched_mode,
  output logic       o_flash,
  output logic [1:0] o_combo,
  output logic [3:0] o_reverse
);

  typedef enum logic [3:0] {
    G_IDLE       = 4'd0,
    G_SCATTER    = 4'd1,
    G_CHASE      = 4'd2,
    G_FRIGHTENED = 4'd3,
    G_DIE        = 4'd4
  } ghost_state_t;

  localparam int MAX_SCHED = (SCATTER_LONG > SCATTER_SHORT) ? SCATTER_LONG : SCATTER_SHORT;
  localparam int MAX_SCHF  = (MAX_SCHED > CHASE_LEN) ? MAX_SCHED : CHASE_LEN;
  localparam int MAX_LEN   = (MAX_SCHF > FRIGHT_LEN) ? MAX_SCHF : FRIGHT_LEN;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t FRIGHT_LOAD = cnt_t'(FRIGHT_LEN);
  localparam cnt_t FLASH_LVL   = cnt_t'(FLASH_LEN);
  localparam cnt_t CNT_ONE     = cnt_t'(1);

  // Length of a schedule phase; phase 7 never counts, so its length is unused.
  function automatic cnt_t phase_len(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: phase_len = cnt_t'(SCATTER_LONG);
      3'd4, 3'd6: phase_len = cnt_t'(SCATTER_SHORT);
      default:    phase_len = cnt_t'(CHASE_LEN);
    endcase
  endfunction

  // Combo index saturates at 3 (the 1600-point eat).
  function automatic logic [1:0] combo_sat_inc(input logic [1:0] c);
    combo_sat_inc = (c == 2'd3) ? c : c + 2'd1;
  endfunction

  logic [2:0]   phase_r;
  cnt_t         sched_cnt_r;
  cnt_t         fright_cnt_r;
  ghost_state_t state_r [4];
  ghost_state_t sched_mode_r;
  logic         flash_r;
  logic [1:0]   combo_r;
  logic [3:0]   reverse_r;

  logic         any_fright;
  logic         any_fright_nxt;
  logic         sched_tick;
  logic         phase_adv;
  logic [2:0]   phase_nxt;
  cnt_t         sched_cnt_nxt;
  ghost_state_t mode_nxt;
  logic         fright_expire;
  cnt_t         fright_cnt_nxt;
  ghost_state_t state_nxt [4];
  logic [3:0]   reverse_nxt;
  logic         any_eat;
  logic [1:0]   combo_nxt;
  logic         flash_nxt;

  // Next-state evaluation: schedule, fright timer, per-ghost mode FSMs, combo and flash.
  always_comb begin
    any_fright = 1'b0;
    for (int g = 0; g < 4; g++) begin
      if (state_r[g] == G_FRIGHTENED) any_fright = 1'b1;
    end

    // The schedule freezes while anyone is frightened and stops for good in phase 7.
    sched_tick    = i_tick && !any_fright && (phase_r != 3'd7);
    phase_adv     = sched_tick && (sched_cnt_r <= CNT_ONE);
    phase_nxt     = phase_adv ? phase_r + 3'd1 : phase_r;
    sched_cnt_nxt = sched_cnt_r;
    if (phase_adv)       sched_cnt_nxt = phase_len(phase_nxt);
    else if (sched_tick) sched_cnt_nxt = sched_cnt_r - CNT_ONE;
    mode_nxt = phase_nxt[0] ? G_CHASE : G_SCATTER;

    // A pellet restarts the fright timer and overrides a same-cycle expiry.
    fright_expire  = i_tick && (fright_cnt_r == CNT_ONE) && !i_power_pellet;
    fright_cnt_nxt = fright_cnt_r;
    if (i_power_pellet)                       fright_cnt_nxt = FRIGHT_LOAD;
    else if (i_tick && fright_cnt_r != '0)    fright_cnt_nxt = fright_cnt_r - CNT_ONE;

    any_eat        = 1'b0;
    any_fright_nxt = 1'b0;
    reverse_nxt    = 4'b0000;
    for (int g = 0; g < 4; g++) begin
      state_nxt[g] = state_r[g];
      case (state_r[g])
        G_IDLE: begin
          if (i_release[g]) state_nxt[g] = mode_nxt;
        end
        G_SCATTER, G_CHASE: begin
          if (i_power_pellet) begin
            state_nxt[g]   = G_FRIGHTENED;
            reverse_nxt[g] = 1'b1;
          end else if (phase_adv) begin
            state_nxt[g]   = mode_nxt;
            reverse_nxt[g] = 1'b1;
          end
        end
        G_FRIGHTENED: begin
          if (i_ghost_eaten[g]) begin
            state_nxt[g] = G_DIE;
            any_eat      = 1'b1;
          end else if (fright_expire) begin
            state_nxt[g] = mode_nxt;
          end
        end
        G_DIE: begin
          if (i_ghost_home[g]) state_nxt[g] = G_IDLE;
        end
        default: state_nxt[g] = G_IDLE;
      endcase
      if (state_nxt[g] == G_FRIGHTENED) any_fright_nxt = 1'b1;
    end

    // Simultaneous eats in one cycle count as a single combo step.
    combo_nxt = combo_r;
    if (i_power_pellet) combo_nxt = 2'd0;
    else if (any_eat)   combo_nxt = combo_sat_inc(combo_r);

    flash_nxt = any_fright_nxt && (fright_cnt_nxt <= FLASH_LVL) && (fright_cnt_nxt != '0);
  end

  // State register; reset and game start take priority over every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_game_start) begin
      phase_r      <= 3'd0;
      sched_cnt_r  <= phase_len(3'd0);
      fright_cnt_r <= '0;
      sched_mode_r <= G_SCATTER;
      flash_r      <= 1'b0;
      reverse_r    <= 4'b0000;
      for (int g = 0; g < 4; g++) state_r[g] <= G_IDLE;
    end else begin
      phase_r      <= phase_nxt;
      sched_cnt_r  <= sched_cnt_nxt;
      fright_cnt_r <= fright_cnt_nxt;
      sched_mode_r <= mode_nxt;
      flash_r      <= flash_nxt;
      reverse_r    <= reverse_nxt;
      for (int g = 0; g < 4; g++) state_r[g] <= state_nxt[g];
    end

    // The combo survives a game start so the last score can still be read.
    if (i_rst)              combo_r <= 2'd0;
    else if (!i_game_start) combo_r <= combo_nxt;
  end

  assign o_blinky_state = state_r[0];
  assign o_pinky_state  = state_r[1];
  assign o_inky_state   = state_r[2];
  assign o_clyde_state  = state_r[3];
  assign o_sched_mode   = sched_mode_r;
  assign o_flash        = flash_r;
  assign o_combo        = combo_r;
  assign o_reverse      = reverse_r;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed testbench for ghost_mode_ctrl.
module tb_ghost_mode_ctrl;

  localparam logic [3:0] G_IDLE       = 4'd0;
  localparam logic [3:0] G_SCATTER    = 4'd1;
  localparam logic [3:0] G_CHASE      = 4'd2;
  localparam logic [3:0] G_FRIGHTENED = 4'd3;
  localparam logic [3:0] G_DIE        = 4'd4;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_game_start = 1'b0;
  logic       i_power_pellet = 1'b0;
  logic [3:0] i_ghost_eaten = 4'b0;
  logic [3:0] i_ghost_home = 4'b0;
  logic [3:0] i_release = 4'b0;
  logic [3:0] o_blinky_state, o_pinky_state, o_inky_state, o_clyde_state;
  logic [3:0] o_sched_mode;
  logic       o_flash;
  logic [1:0] o_combo;
  logic [3:0] o_reverse;
  logic [15:0] st;

  int checks = 0;
  int errors = 0;

  ghost_mode_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_tick(i_tick), .i_game_start(i_game_start),
    .i_power_pellet(i_power_pellet), .i_ghost_eaten(i_ghost_eaten),
    .i_ghost_home(i_ghost_home), .i_release(i_release),
    .o_blinky_state(o_blinky_state), .o_pinky_state(o_pinky_state),
    .o_inky_state(o_inky_state), .o_clyde_state(o_clyde_state),
    .o_sched_mode(o_sched_mode), .o_flash(o_flash), .o_combo(o_combo),
    .o_reverse(o_reverse)
  );

  always #5 i_clk = ~i_clk;

  assign st = {o_clyde_state, o_inky_state, o_pinky_state, o_blinky_state};

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    i_tick = 1'b1;
    repeat (n) cyc();
    i_tick = 1'b0;
  endtask

  task automatic do_rst();
    i_rst = 1'b1; cyc(); i_rst = 1'b0;
  endtask

  task automatic release_all();
    i_release = 4'b1111; cyc(); i_release = 4'b0000;
  endtask

  task automatic pellet();
    i_power_pellet = 1'b1; cyc(); i_power_pellet = 1'b0;
  endtask

  task automatic eat(input logic [3:0] m);
    i_ghost_eaten = m; cyc(); i_ghost_eaten = 4'b0;
  endtask

  task automatic test_reset();
    i_ghost_eaten = 4'b1111; i_power_pellet = 1'b1;
    do_rst();
    i_ghost_eaten = 4'b0000; i_power_pellet = 1'b0;
    checks++; if (st !== 16'h0000) begin errors++; $display("FAIL reset_states got %h exp %h", st, 16'h0000); end
    checks++; if (o_sched_mode !== G_SCATTER) begin errors++; $display("FAIL reset_mode got %0d exp %0d", o_sched_mode, G_SCATTER); end
    checks++; if ({o_flash, o_combo, o_reverse} !== 7'b0) begin errors++; $display("FAIL reset_misc got %b exp 0", {o_flash, o_combo, o_reverse}); end
  endtask

  task automatic test_schedule();
    int revs;
    do_rst();
    release_all();
    checks++; if (st !== {4{G_SCATTER}}) begin errors++; $display("FAIL release_scatter got %h exp %h", st, {4{G_SCATTER}}); end
    ticks(419);
    checks++; if (st !== {4{G_SCATTER}}) begin errors++; $display("FAIL scatter_419 got %h exp %h", st, {4{G_SCATTER}}); end
    ticks(1);
    checks++; if (st !== {4{G_CHASE}} || o_sched_mode !== G_CHASE) begin errors++; $display("FAIL chase_420 got %h mode %0d exp %h", st, o_sched_mode, {4{G_CHASE}}); end
    checks++; if (o_reverse !== 4'b1111) begin errors++; $display("FAIL rev_phase1 got %b exp 1111", o_reverse); end
    cyc();
    checks++; if (o_reverse !== 4'b0000) begin errors++; $display("FAIL rev_one_cycle got %b exp 0000", o_reverse); end
    ticks(1200);
    checks++; if (st !== {4{G_SCATTER}} || o_sched_mode !== G_SCATTER) begin errors++; $display("FAIL scatter_1620 got %h mode %0d", st, o_sched_mode); end
    // Phases 0..6 total 5040 ticks.
    ticks(5039 - 1620);
    checks++; if (o_sched_mode !== G_SCATTER) begin errors++; $display("FAIL phase6_end got %0d exp %0d", o_sched_mode, G_SCATTER); end
    ticks(1);
    checks++; if (o_sched_mode !== G_CHASE || o_reverse !== 4'b1111) begin errors++; $display("FAIL phase7 mode %0d rev %b exp 2 1111", o_sched_mode, o_reverse); end
    revs = 0;
    i_tick = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cyc();
      if (o_reverse !== 4'b0000) revs++;
    end
    i_tick = 1'b0;
    checks++; if (revs !== 0 || o_sched_mode !== G_CHASE || st !== {4{G_CHASE}}) begin errors++; $display("FAIL phase7_hold revs %0d mode %0d st %h exp 0 2 %h", revs, o_sched_mode, st, {4{G_CHASE}}); end
  endtask

  task automatic test_fright();
    do_rst();
    i_release = 4'b0111; cyc(); i_release = 4'b0000;
    ticks(420 + 700);
    pellet();
    checks++; if (st !== {G_IDLE, G_FRIGHTENED, G_FRIGHTENED, G_FRIGHTENED}) begin errors++; $display("FAIL pellet_states got %h exp %h", st, {G_IDLE, G_FRIGHTENED, G_FRIGHTENED, G_FRIGHTENED}); end
    checks++; if (o_reverse !== 4'b0111) begin errors++; $display("FAIL pellet_rev got %b exp 0111", o_reverse); end
    ticks(239);
    checks++; if (o_flash !== 1'b0) begin errors++; $display("FAIL flash_239 got %b exp 0", o_flash); end
    ticks(1);
    checks++; if (o_flash !== 1'b1) begin errors++; $display("FAIL flash_240 got %b exp 1", o_flash); end
    ticks(119);
    checks++; if (o_blinky_state !== G_FRIGHTENED) begin errors++; $display("FAIL fright_359 got %0d exp %0d", o_blinky_state, G_FRIGHTENED); end
    ticks(1);
    checks++; if (st !== {G_IDLE, G_CHASE, G_CHASE, G_CHASE} || o_flash !== 1'b0) begin errors++; $display("FAIL fright_expire got %h flash %b", st, o_flash); end
    // Schedule was paused at 500 remaining.
    ticks(499);
    checks++; if (o_sched_mode !== G_CHASE) begin errors++; $display("FAIL paused_499 got %0d exp %0d", o_sched_mode, G_CHASE); end
    ticks(1);
    checks++; if (o_sched_mode !== G_SCATTER || o_blinky_state !== G_SCATTER) begin errors++; $display("FAIL paused_500 mode %0d blinky %0d exp 1 1", o_sched_mode, o_blinky_state); end
  endtask

  task automatic test_combo();
    do_rst();
    release_all();
    ticks(10);
    pellet();
    eat(4'b0001);
    checks++; if (o_combo !== 2'd1 || o_blinky_state !== G_DIE) begin errors++; $display("FAIL eat1 combo %0d blinky %0d exp 1 4", o_combo, o_blinky_state); end
    eat(4'b0010);
    checks++; if (o_combo !== 2'd2 || o_pinky_state !== G_DIE) begin errors++; $display("FAIL eat2 combo %0d pinky %0d exp 2 4", o_combo, o_pinky_state); end
    eat(4'b1100);
    checks++; if (o_combo !== 2'd3 || st !== {4{G_DIE}}) begin errors++; $display("FAIL eat34 combo %0d st %h exp 3 %h", o_combo, st, {4{G_DIE}}); end
    eat(4'b1111);
    checks++; if (o_combo !== 2'd3 || st !== {4{G_DIE}}) begin errors++; $display("FAIL eat_die_ignored combo %0d st %h", o_combo, st); end
    i_ghost_home = 4'b0001; cyc(); i_ghost_home = 4'b0000;
    checks++; if (st !== {G_DIE, G_DIE, G_DIE, G_IDLE}) begin errors++; $display("FAIL home got %h exp %h", st, {G_DIE, G_DIE, G_DIE, G_IDLE}); end
    i_release = 4'b0001; cyc(); i_release = 4'b0000;
    checks++; if (o_blinky_state !== G_SCATTER) begin errors++; $display("FAIL rerelease got %0d exp %0d", o_blinky_state, G_SCATTER); end
  endtask

  task automatic test_pellet_expiry();
    do_rst();
    release_all();
    pellet();
    ticks(359);
    eat(4'b0001);
    checks++; if (o_combo !== 2'd1) begin errors++; $display("FAIL pre_combo got %0d exp 1", o_combo); end
    i_tick = 1'b1; i_power_pellet = 1'b1; cyc(); i_tick = 1'b0; i_power_pellet = 1'b0;
    checks++; if (st !== {G_FRIGHTENED, G_FRIGHTENED, G_FRIGHTENED, G_DIE} || o_combo !== 2'd0) begin errors++; $display("FAIL pellet_on_expiry st %h combo %0d", st, o_combo); end
    ticks(239);
    checks++; if (o_flash !== 1'b0) begin errors++; $display("FAIL reload_flash_239 got %b exp 0", o_flash); end
    ticks(1);
    checks++; if (o_flash !== 1'b1) begin errors++; $display("FAIL reload_flash_240 got %b exp 1", o_flash); end
  endtask

  task automatic test_game_start();
    do_rst();
    release_all();
    pellet();
    eat(4'b0001);
    eat(4'b0010);
    ticks(240);
    checks++; if (o_flash !== 1'b1 || o_combo !== 2'd2) begin errors++; $display("FAIL gs_setup flash %b combo %0d exp 1 2", o_flash, o_combo); end
    i_game_start = 1'b1; i_power_pellet = 1'b1; i_release = 4'b1111;
    cyc();
    i_game_start = 1'b0; i_power_pellet = 1'b0; i_release = 4'b0000;
    checks++; if (st !== 16'h0000 || o_sched_mode !== G_SCATTER) begin errors++; $display("FAIL gs_states st %h mode %0d", st, o_sched_mode); end
    checks++; if (o_flash !== 1'b0 || o_combo !== 2'd2 || o_reverse !== 4'b0) begin errors++; $display("FAIL gs_misc flash %b combo %0d rev %b exp 0 2 0", o_flash, o_combo, o_reverse); end
    release_all();
    ticks(419);
    checks++; if (o_sched_mode !== G_SCATTER) begin errors++; $display("FAIL gs_phase0 got %0d exp %0d", o_sched_mode, G_SCATTER); end
    ticks(1);
    checks++; if (o_sched_mode !== G_CHASE) begin errors++; $display("FAIL gs_phase1 got %0d exp %0d", o_sched_mode, G_CHASE); end
    do_rst();
    checks++; if (o_combo !== 2'd0) begin errors++; $display("FAIL rst_combo got %0d exp 0", o_combo); end
  endtask

  initial begin
    cyc();
    test_reset();
    test_schedule();
    test_fright();
    test_combo();
    test_pellet_expiry();
    test_game_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
